// File: rtl/regfile_mp.sv
// Parametrised multi-read-port register file with optional write bypass,
// hardwired zero register and a post-reset clear sequencer.
module regfile_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_RD     = 2,
  parameter int BYPASS     = 1,
  parameter int ZERO_REG   = 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         w_ena,
  input  logic [ADDR_WIDTH-1:0]        w_addr,
  input  logic [DATA_WIDTH-1:0]        w_data,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] r_addr,
  output logic [NUM_RD*DATA_WIDTH-1:0] r_data,
  output logic                         busy
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {CLEAR, RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic                  w_live;
  logic                  clear_we;
  logic [ADDR_WIDTH-1:0] rd_addr;

  // A write is live only in RUN, outside reset, and not aimed at a hardwired r0.
  always_comb begin
    w_live   = w_ena && !rst && (state == RUN) &&
               !((ZERO_REG != 0) && (w_addr == '0));
    clear_we = !rst && (state == CLEAR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_cnt <= '0;
      busy    <= 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clr_cnt <= clr_cnt + ADDR_WIDTH'(1);
          if (clr_cnt == '1) begin
            state <= RUN;
            busy  <= 1'b0;
          end
        end
        RUN: state <= RUN;
        default: state <= CLEAR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (clear_we)
      mem[clr_cnt] <= '0;
    else if (w_live)
      mem[w_addr] <= w_data;
  end

  always_comb begin
    r_data  = '0;
    rd_addr = '0;
    for (int unsigned k = 0; k < NUM_RD; k++) begin
      rd_addr = r_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (busy)
        r_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if ((ZERO_REG != 0) && (rd_addr == '0))
        r_data[k*DATA_WIDTH +: DATA_WIDTH] = '0;
      else if ((BYPASS != 0) && w_live && (w_addr == rd_addr))
        r_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
      else
        r_data[k*DATA_WIDTH +: DATA_WIDTH] = mem[rd_addr];
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: default, no-bypass and a narrow 4-port variant
// checked against an array-based model of the register file.
module tb_regfile_mp;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        w_ena = 1'b0;
  logic [4:0]  w_addr = '0;
  logic [31:0] w_data = '0;
  logic [9:0]  r_addr01 = '0;
  logic [63:0] r_data0, r_data1;
  logic        busy0, busy1;

  logic        w_ena2 = 1'b0;
  logic [2:0]  w_addr2 = '0;
  logic [15:0] w_data2 = '0;
  logic [11:0] r_addr2 = '0;
  logic [63:0] r_data2;
  logic        busy2;

  int passed = 0;
  int total  = 0;

  logic [31:0] mem  [32];
  logic [15:0] mem2 [8];
  int busy_left  = 0;
  int busy2_left = 0;

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(1), .ZERO_REG(1)) dut0 (
    .clk(clk), .rst(rst), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr01), .r_data(r_data0), .busy(busy0));

  regfile_mp #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_RD(2), .BYPASS(0), .ZERO_REG(1)) dut1 (
    .clk(clk), .rst(rst), .w_ena(w_ena), .w_addr(w_addr), .w_data(w_data),
    .r_addr(r_addr01), .r_data(r_data1), .busy(busy1));

  regfile_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .NUM_RD(4), .BYPASS(1), .ZERO_REG(0)) dut2 (
    .clk(clk), .rst(rst), .w_ena(w_ena2), .w_addr(w_addr2), .w_data(w_data2),
    .r_addr(r_addr2), .r_data(r_data2), .busy(busy2));

  // Expected read of one 32-bit port from the register-file rules.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (busy_left > 0) return 32'h0;
    if (a == 5'd0) return 32'h0;
    if (byp && w_ena && !rst && w_addr == a) return w_data;
    return mem[a];
  endfunction

  function automatic logic [63:0] exp01(input bit byp);
    return {exp_rd(r_addr01[9:5], byp), exp_rd(r_addr01[4:0], byp)};
  endfunction

  function automatic logic [63:0] exp2();
    logic [63:0] r;
    logic [2:0]  a;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      a = r_addr2[k*3 +: 3];
      if (busy2_left > 0) r[k*16 +: 16] = 16'h0;
      else if (w_ena2 && !rst && w_addr2 == a) r[k*16 +: 16] = w_data2;
      else r[k*16 +: 16] = mem2[a];
    end
    return r;
  endfunction

  task automatic model_update();
    if (rst) begin
      busy_left  = 32;
      busy2_left = 8;
      for (int i = 0; i < 32; i++) mem[i] = '0;
      for (int i = 0; i < 8; i++) mem2[i] = '0;
    end else begin
      if (busy_left > 0) busy_left--;
      else if (w_ena && w_addr != 5'd0) mem[w_addr] = w_data;
      if (busy2_left > 0) busy2_left--;
      else if (w_ena2) mem2[w_addr2] = w_data2;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; w_ena = 1'b1; w_addr = 5'd3; w_data = 32'h55;
    w_ena2 = 1'b1; w_addr2 = 3'd3; w_data2 = 16'h55;
    cycle();
    rst = 1'b0; w_ena = 1'b0; w_ena2 = 1'b0;
    for (int i = 0; i < 32; i++) begin
      w_ena = (i == 5);
      w_addr = 5'd9; w_data = 32'h1234;
      r_addr01 = {5'd9, 5'd3};
      #1;
      total++;
      if (busy0 !== 1'b1 || busy1 !== 1'b1) $display("FAIL busy_clear cyc=%0d got %b/%b want 1", i, busy0, busy1);
      else passed++;
      total++;
      if (busy2 !== (busy2_left > 0)) $display("FAIL busy2_clear cyc=%0d got %b want %b", i, busy2, busy2_left > 0);
      else passed++;
      total++;
      if (r_data0 !== 64'h0) $display("FAIL rd_while_busy cyc=%0d got %h want 0", i, r_data0);
      else passed++;
      cycle();
    end
    w_ena = 1'b0;
    #1;
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL busy_done got %b/%b want 0", busy0, busy1);
    else passed++;
  endtask

  task automatic test_clear_contents();
    for (int a = 0; a < 32; a++) begin
      r_addr01 = {a[4:0], a[4:0]};
      r_addr2  = {4{a[2:0]}};
      #1;
      total++;
      if (r_data0 !== 64'h0 || r_data0 !== exp01(1'b1)) $display("FAIL clear_rd0 a=%0d got %h want 0", a, r_data0);
      else passed++;
      total++;
      if (r_data1 !== 64'h0) $display("FAIL clear_rd1 a=%0d got %h want 0", a, r_data1);
      else passed++;
      if (a < 8) begin
        total++;
        if (r_data2 !== 64'h0) $display("FAIL clear_rd2 a=%0d got %h want 0", a, r_data2);
        else passed++;
      end
    end
  endtask

  task automatic test_write_read();
    w_ena = 1'b1; w_addr = 5'd5; w_data = 32'hDEADBEEF;
    cycle();
    w_addr = 5'd0; w_data = 32'hFFFFFFFF;
    cycle();
    w_ena = 1'b0;
    r_addr01 = {5'd0, 5'd5};
    #1;
    total++;
    if (r_data0 !== {32'h0, 32'hDEADBEEF} || r_data0 !== exp01(1'b1))
      $display("FAIL write_read0 got %h want %h", r_data0, {32'h0, 32'hDEADBEEF});
    else passed++;
    total++;
    if (r_data1 !== {32'h0, 32'hDEADBEEF}) $display("FAIL write_read1 got %h want %h", r_data1, {32'h0, 32'hDEADBEEF});
    else passed++;
  endtask

  task automatic test_bypass();
    w_ena = 1'b1; w_addr = 5'd7; w_data = 32'hCAFE0001;
    r_addr01 = {5'd7, 5'd5};
    #1;
    total++;
    if (r_data0[63:32] !== 32'hCAFE0001) $display("FAIL bypass_same got %h want cafe0001", r_data0[63:32]);
    else passed++;
    total++;
    if (r_data1[63:32] !== 32'h0 || r_data1 !== exp01(1'b0)) $display("FAIL nobypass_old got %h want 0", r_data1[63:32]);
    else passed++;
    cycle();
    w_ena = 1'b0;
    #1;
    total++;
    if (r_data1[63:32] !== 32'hCAFE0001) $display("FAIL nobypass_next got %h want cafe0001", r_data1[63:32]);
    else passed++;
    total++;
    if (r_data0 !== exp01(1'b1)) $display("FAIL bypass_next got %h want %h", r_data0, exp01(1'b1));
    else passed++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      w_ena   = 1'($urandom_range(0, 1));
      w_addr  = 5'($urandom_range(0, 9));
      w_data  = $urandom;
      r_addr01 = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 31))};
      w_ena2  = 1'($urandom_range(0, 1));
      w_addr2 = 3'($urandom);
      w_data2 = 16'($urandom);
      r_addr2 = 12'($urandom);
      #1;
      total++;
      if (r_data0 !== exp01(1'b1)) $display("FAIL rand_rd0 i=%0d got %h want %h", i, r_data0, exp01(1'b1));
      else passed++;
      total++;
      if (r_data1 !== exp01(1'b0)) $display("FAIL rand_rd1 i=%0d got %h want %h", i, r_data1, exp01(1'b0));
      else passed++;
      total++;
      if (r_data2 !== exp2()) $display("FAIL rand_rd2 i=%0d got %h want %h", i, r_data2, exp2());
      else passed++;
      cycle();
    end
    w_ena = 1'b0; w_ena2 = 1'b0;
  endtask

  task automatic test_mid_clear();
    w_ena = 1'b1; w_addr = 5'd20; w_data = 32'h77;
    cycle();
    w_ena = 1'b0; r_addr01 = {5'd20, 5'd20};
    #1;
    total++;
    if (r_data0 !== {2{32'h77}}) $display("FAIL pre_reset20 got %h want %h", r_data0, {2{32'h77}});
    else passed++;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      #1;
      total++;
      if (busy0 !== 1'b1) $display("FAIL busy_restart cyc=%0d got %b want 1", i, busy0);
      else passed++;
      cycle();
    end
    #1;
    total++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) $display("FAIL busy_restart_done got %b/%b want 0", busy0, busy1);
    else passed++;
    for (int a = 0; a < 32; a++) begin
      r_addr01 = {a[4:0], a[4:0]};
      #1;
      total++;
      if (r_data0 !== 64'h0 || r_data1 !== 64'h0) $display("FAIL restart_rd a=%0d got %h/%h want 0", a, r_data0, r_data1);
      else passed++;
    end
  endtask

  task automatic test_param();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #1;
      total++;
      if (busy2 !== 1'b1) $display("FAIL p_busy cyc=%0d got %b want 1", i, busy2);
      else passed++;
      cycle();
    end
    #1;
    total++;
    if (busy2 !== 1'b0) $display("FAIL p_busy_done got %b want 0", busy2);
    else passed++;
    w_ena2 = 1'b1; w_addr2 = 3'd0; w_data2 = 16'hA5A5; r_addr2 = '0;
    #1;
    total++;
    if (r_data2 !== {4{16'hA5A5}}) $display("FAIL p_bypass got %h want %h", r_data2, {4{16'hA5A5}});
    else passed++;
    cycle();
    w_ena2 = 1'b0;
    #1;
    total++;
    if (r_data2 !== {4{16'hA5A5}} || r_data2 !== exp2()) $display("FAIL p_addr0 got %h want %h", r_data2, {4{16'hA5A5}});
    else passed++;
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clear_contents();
    test_write_read();
    test_bypass();
    test_random();
    test_mid_clear();
    test_param();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
